// File: rtl/pokey_pkg.sv
// Shared types and POKEY register map for the POKEY bus arbiter.
package pokey_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] AUDF1  = 4'h0;
  localparam logic [3:0] AUDC1  = 4'h1;
  localparam logic [3:0] AUDF2  = 4'h2;
  localparam logic [3:0] AUDC2  = 4'h3;
  localparam logic [3:0] AUDF3  = 4'h4;
  localparam logic [3:0] AUDC3  = 4'h5;
  localparam logic [3:0] AUDF4  = 4'h6;
  localparam logic [3:0] AUDC4  = 4'h7;
  localparam logic [3:0] AUDCTL = 4'h8;
  localparam logic [3:0] ALLPOT = 4'h8;
  localparam logic [3:0] RANDOM = 4'hA;
  localparam logic [3:0] POTGO  = 4'hB;
  localparam logic [3:0] SEROUT = 4'hD;
  localparam logic [3:0] SERIN  = 4'hD;
  localparam logic [3:0] SKCTL  = 4'hF;

endpackage

// File: rtl/pokey_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant; the remembered last winner only moves when a grant is taken.
module rr_arb2
  import pokey_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic       grant,
  output logic       valid
);

  logic last_grant;

  always_comb begin
    valid = en && (req != 2'b00);
    grant = (req == 2'b11) ? ~last_grant : req[1];
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      last_grant <= 1'b1;
    end else if (valid) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/pokey_bus_arbiter.sv
// Arbitrates the POKEY register bus between the CPU bridge (port 0) and the
// sound sequencer (port 1), running one complete phi2-strobed bus cycle per grant.
module pokey_bus_arbiter
  import pokey_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int HIGH_CYC  = 4,
  parameter int HOLD_CYC  = 2
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] req,
  input  logic [1:0] rnw,
  input  logic [3:0] addr0,
  input  logic [3:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] ack,
  output logic [7:0] rdata,
  output logic       busy,
  output logic [3:0] A,
  output logic [7:0] Din,
  input  logic [7:0] Dout,
  output logic       readHighWriteLow,
  output logic       cs0Bar,
  output logic       phi2
);

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
  localparam logic [3:0] HIGH_LAST  = 4'(HIGH_CYC - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYC - 1);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;

  logic       lat_port;
  logic       lat_rnw;
  logic [3:0] lat_addr;
  logic [7:0] lat_wdata;

  logic       grant, valid;
  logic       cyc_rnw;
  logic [3:0] cyc_addr;
  logic [7:0] cyc_wdata;
  logic       bus_on;

  rr_arb2 u_arb (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (state == IDLE),
    .req   (req),
    .grant (grant),
    .valid (valid)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 4'd1;
    unique case (state)
      IDLE: begin
        cnt_next = 4'd0;
        if (valid) state_next = SETUP;
      end
      SETUP: if (cnt == SETUP_LAST) begin
        state_next = STROBE;
        cnt_next   = 4'd0;
      end
      STROBE: if (cnt == HIGH_LAST) begin
        state_next = HOLD;
        cnt_next   = 4'd0;
      end
      HOLD: if (cnt == HOLD_LAST) begin
        state_next = DONE;
        cnt_next   = 4'd0;
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Outputs are registered from the next state, so on the grant edge the bus
  // must be driven from the winner's live inputs rather than the latches.
  always_comb begin
    if (state == IDLE) begin
      cyc_rnw   = grant ? rnw[1]  : rnw[0];
      cyc_addr  = grant ? addr1   : addr0;
      cyc_wdata = grant ? wdata1  : wdata0;
    end else begin
      cyc_rnw   = lat_rnw;
      cyc_addr  = lat_addr;
      cyc_wdata = lat_wdata;
    end
    bus_on = (state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      lat_port         <= 1'b0;
      lat_rnw          <= 1'b1;
      lat_addr         <= 4'd0;
      lat_wdata        <= 8'h00;
      ack              <= 2'b00;
      rdata            <= 8'h00;
      busy             <= 1'b0;
      A                <= 4'd0;
      Din              <= 8'h00;
      readHighWriteLow <= 1'b1;
      cs0Bar           <= 1'b1;
      phi2             <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == IDLE && valid) begin
        lat_port  <= grant;
        lat_rnw   <= cyc_rnw;
        lat_addr  <= cyc_addr;
        lat_wdata <= cyc_wdata;
      end
      busy             <= (state_next != IDLE);
      cs0Bar           <= ~bus_on;
      readHighWriteLow <= bus_on ? cyc_rnw : 1'b1;
      phi2             <= (state_next == STROBE);
      if (bus_on) begin
        A   <= cyc_addr;
        Din <= cyc_rnw ? 8'h00 : cyc_wdata;
      end
      ack <= (state_next == DONE) ? (lat_port ? 2'b10 : 2'b01) : 2'b00;
      if (state == HOLD && state_next == DONE && lat_rnw) begin
        rdata <= Dout;
      end
    end
  end

endmodule

// File: tb/tb_pokey_bus_arbiter.sv
// Bench for pokey_bus_arbiter: vector table, corner-case sequences, and a
// randomized run checked against a transaction-level arbitration model.
module tb_pokey_bus_arbiter;
  import pokey_pkg::*;

  localparam int S  = 2;
  localparam int H  = 4;
  localparam int HD = 2;
  localparam int LAT    = 1 + S + H + HD;
  localparam int PERIOD = 2 + S + H + HD;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [1:0] req;
  logic [1:0] rnw;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic [1:0] ack;
  logic [7:0] rdata;
  logic       busy;
  logic [3:0] a_bus;
  logic [7:0] din_bus;
  logic [7:0] dout_bus;
  logic       rhwl, cs0_bar, phi2;

  logic [1:0] f_req;
  logic [3:0] f_addr0;
  logic [7:0] f_wdata0;
  logic [1:0] f_ack;
  logic [7:0] f_rdata;
  logic       f_busy, f_rhwl, f_cs, f_phi2;
  logic [3:0] f_a;
  logic [7:0] f_din;

  always #5 clk = ~clk;

  pokey_bus_arbiter #(.SETUP_CYC(S), .HIGH_CYC(H), .HOLD_CYC(HD)) dut (
    .clk(clk), .clr_n(clr_n), .req(req), .rnw(rnw),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata(rdata), .busy(busy), .A(a_bus), .Din(din_bus),
    .Dout(dout_bus), .readHighWriteLow(rhwl), .cs0Bar(cs0_bar), .phi2(phi2)
  );

  pokey_bus_arbiter #(.SETUP_CYC(1), .HIGH_CYC(1), .HOLD_CYC(1)) dut_fast (
    .clk(clk), .clr_n(clr_n), .req(f_req), .rnw(2'b00),
    .addr0(f_addr0), .addr1(4'h0), .wdata0(f_wdata0), .wdata1(8'h00),
    .ack(f_ack), .rdata(f_rdata), .busy(f_busy), .A(f_a), .Din(f_din),
    .Dout(8'h00), .readHighWriteLow(f_rhwl), .cs0Bar(f_cs), .phi2(f_phi2)
  );

  // POKEY model: acts on the clk edge where phi2 is first seen high.
  logic       pk_init;
  logic [7:0] pk_regs [16];
  logic [7:0] f_regs  [16];
  logic       pk_phi2_q, f_phi2_q;
  logic [7:0] rng, rng_snap;

  always @(posedge clk) begin
    if (pk_init) begin
      for (int i = 0; i < 16; i++) begin
        pk_regs[i] <= 8'h00;
        f_regs[i]  <= 8'h00;
      end
      rng       <= 8'hA5;
      rng_snap  <= 8'h00;
      dout_bus  <= 8'h00;
      pk_phi2_q <= 1'b0;
      f_phi2_q  <= 1'b0;
    end else begin
      rng       <= {rng[6:0], rng[7] ^ rng[5] ^ rng[4] ^ rng[3]};
      pk_phi2_q <= phi2;
      f_phi2_q  <= f_phi2;
      if (phi2 && !pk_phi2_q && !cs0_bar) begin
        if (!rhwl) pk_regs[a_bus] <= din_bus;
        else begin
          dout_bus <= (a_bus == RANDOM) ? rng : pk_regs[a_bus];
          rng_snap <= rng;
        end
      end
      if (f_phi2 && !f_phi2_q && !f_cs && !f_rhwl) f_regs[f_a] <= f_din;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    tick();
  endtask

  task automatic run_single(input bit port, input bit r, input logic [3:0] a, input logic [7:0] d,
                            input bit mutate, output int lat, output int cs_low, output int ph_high,
                            output int rises, output bit win_ok, output bit other_ack,
                            output logic [7:0] rd);
    logic prev_ph;
    lat = 0; cs_low = 0; ph_high = 0; rises = 0; win_ok = 1'b1; other_ack = 1'b0;
    prev_ph = 1'b0; rd = 8'h00;
    rnw[port] = r;
    if (port == 1'b0) begin addr0 = a; wdata0 = d; end
    else begin addr1 = a; wdata1 = d; end
    req[port] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (mutate && c == 1) begin addr0 = AUDC4; wdata0 = 8'h55; end
      if (!cs0_bar) cs_low++;
      if (phi2) ph_high++;
      if (phi2 && !prev_ph) begin rises++; if (cs0_bar) win_ok = 1'b0; end
      if (!phi2 && prev_ph && cs0_bar) win_ok = 1'b0;
      prev_ph = phi2;
      if (ack[port ? 0 : 1]) other_ack = 1'b1;
      if (ack[port]) begin
        lat = c;
        rd = rdata;
        req[port] = 1'b0;
        break;
      end
    end
    $display("txn port=%0d %s addr=0x%0h wdata=0x%02h lat=%0d rdata=0x%02h", port,
             r ? "RD" : "WR", a, d, lat, rd);
  endtask

  // Both ports request continuously; port p's k-th write goes to 2k+p.
  task automatic contend(input int n_each, output int first_port);
    int idx [2];
    int last_port, last_e, n_acks;
    idx[0] = 0; idx[1] = 0; last_port = -1; last_e = 0; n_acks = 0; first_port = -1;
    rnw = 2'b00;
    addr0 = 4'd0; wdata0 = 8'h40;
    addr1 = 4'd1; wdata1 = 8'h41;
    req = 2'b11;
    for (int e = 1; e <= 40 * n_each + 60; e++) begin
      tick();
      if (ack == 2'b11) check("contend_dual_ack", {30'd0, ack}, 32'd1);
      for (int p = 0; p < 2; p++) begin
        if (ack[p]) begin
          if (first_port < 0) first_port = p;
          else begin
            check("contend_alternate", p, 1 - last_port);
            check("contend_period", e - last_e, PERIOD);
          end
          $display("txn contend port=%0d ack at cycle %0d", p, e);
          last_port = p; last_e = e; n_acks++;
          idx[p]++;
          if (idx[p] < n_each) begin
            if (p == 0) begin addr0 = 4'(2 * idx[p]); wdata0 = 8'(8'h40 + 2 * idx[p]); end
            else begin addr1 = 4'(2 * idx[p] + 1); wdata1 = 8'(8'h41 + 2 * idx[p]); end
          end else req[p] = 1'b0;
        end
      end
      if (n_acks == 2 * n_each) break;
    end
    check("contend_ack_count", n_acks, 2 * n_each);
  endtask

  typedef struct {
    bit         port;
    bit         r;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat, cs_low, ph_high, rises, first;
    bit win_ok, other_ack;
    logic [7:0] rd;

    pk_init = 1'b1;
    clr_n = 1'b0;
    req = 2'b00; rnw = 2'b11;
    addr0 = 4'd0; addr1 = 4'd0; wdata0 = 8'h00; wdata1 = 8'h00;
    f_req = 2'b00; f_addr0 = 4'd0; f_wdata0 = 8'h00;
    repeat (3) tick();

    check("rst_ack", {30'd0, ack}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_A", {28'd0, a_bus}, 32'd0);
    check("rst_Din", {24'd0, din_bus}, 32'h00);
    check("rst_rhwl", {31'd0, rhwl}, 32'd1);
    check("rst_cs0Bar", {31'd0, cs0_bar}, 32'd1);
    check("rst_phi2", {31'd0, phi2}, 32'd0);

    pk_init = 1'b0;
    clr_n = 1'b1;
    tick();

    vecs[0] = '{1'b0, 1'b0, AUDC1,  8'hAF, 8'h00};
    vecs[1] = '{1'b1, 1'b0, SKCTL,  8'h03, 8'h00};
    vecs[2] = '{1'b1, 1'b0, AUDF2,  8'h3C, 8'h00};
    vecs[3] = '{1'b0, 1'b1, AUDF2,  8'h00, 8'h3C};
    vecs[4] = '{1'b1, 1'b1, AUDC1,  8'h00, 8'hAF};
    vecs[5] = '{1'b0, 1'b0, AUDCTL, 8'h01, 8'h00};

    for (int i = 0; i < 6; i++) begin
      run_single(vecs[i].port, vecs[i].r, vecs[i].a, vecs[i].d, 1'b0,
                 lat, cs_low, ph_high, rises, win_ok, other_ack, rd);
      check("vec_latency", lat, LAT);
      check("vec_cs_low_cycles", cs_low, S + H + HD);
      check("vec_phi2_high_cycles", ph_high, H);
      check("vec_phi2_rises", rises, 1);
      check("vec_phi2_in_window", {31'd0, win_ok}, 32'd1);
      check("vec_other_ack", {31'd0, other_ack}, 32'd0);
      if (vecs[i].r) check("vec_rdata", {24'd0, rd}, {24'd0, vecs[i].exp_rd});
      tick();
      check("vec_ack_clear", {30'd0, ack}, 32'd0);
      check("vec_idle_after", {31'd0, busy}, 32'd0);
      check("vec_rdata_held", {24'd0, rdata}, {24'd0, rd});
      if (!vecs[i].r) check("vec_pokey_reg", {24'd0, pk_regs[vecs[i].a]}, {24'd0, vecs[i].d});
    end

    // RANDOM read returns what POKEY drove at the phi2 edge
    run_single(1'b1, 1'b1, RANDOM, 8'h00, 1'b0, lat, cs_low, ph_high, rises, win_ok, other_ack, rd);
    check("random_rdata", {24'd0, rd}, {24'd0, rng_snap});
    tick();
    check("random_rdata_held", {24'd0, rdata}, {24'd0, rng_snap});

    // requester inputs change during SETUP: the latched cycle must be unaffected
    run_single(1'b0, 1'b0, AUDF1, 8'h12, 1'b1, lat, cs_low, ph_high, rises, win_ok, other_ack, rd);
    tick();
    check("latch_audf1", {24'd0, pk_regs[AUDF1]}, 32'h12);
    check("latch_audc4", {24'd0, pk_regs[AUDC4]}, 32'h00);

    // contention from reset: port 0 first, strict alternation
    pulse_reset();
    contend(4, first);
    check("contend_first", first, 0);
    tick();
    for (int i = 0; i < 8; i++)
      check("contend_reg", {24'd0, pk_regs[i]}, 32'h40 + i);

    // reset in the middle of STROBE after POKEY has seen phi2
    rnw[0] = 1'b0; addr0 = AUDF3; wdata0 = 8'h99; req[0] = 1'b1;
    repeat (4) tick();
    check("abort_phi2_before", {31'd0, phi2}, 32'd1);
    clr_n = 1'b0;
    req = 2'b00;
    #1;
    check("abort_phi2", {31'd0, phi2}, 32'd0);
    check("abort_cs0Bar", {31'd0, cs0_bar}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_ack", {30'd0, ack}, 32'd0);
    end
    clr_n = 1'b1;
    tick();
    check("abort_committed", {24'd0, pk_regs[AUDF3]}, 32'h99);
    contend(1, first);
    check("abort_then_port0", first, 0);

    // short timing parameters
    f_addr0 = AUDCTL; f_wdata0 = 8'h01; f_req = 2'b01;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (f_ack[0]) begin lat = c; f_req = 2'b00; break; end
    end
    $display("txn fast port=0 WR addr=0x8 wdata=0x01 lat=%0d", lat);
    check("fast_latency", lat, 4);
    tick();
    check("fast_committed", {24'd0, f_regs[AUDCTL]}, 32'h01);

    // randomized traffic against a transaction-level model
    begin
      logic [7:0] m_mem [16];
      bit         pend [2];
      int         m_last, m_free, m_ack_e, m_port, n_acc;
      bit         m_busy, m_rnw;
      logic [3:0] m_addr;
      logic [7:0] m_wd;
      logic [1:0] s_req, s_rnw, exp_ack;
      logic [3:0] s_a0, s_a1;
      logic [7:0] s_w0, s_w1;

      pulse_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = pk_regs[i];
      pend[0] = 1'b0; pend[1] = 1'b0;
      m_last = 1; m_free = 0; m_busy = 1'b0; m_ack_e = 0; m_port = 0; n_acc = 0;
      m_rnw = 1'b0; m_addr = 4'd0; m_wd = 8'h00;
      req = 2'b00;
      for (int e = 1; e <= 1600; e++) begin
        s_req = req; s_rnw = rnw; s_a0 = addr0; s_a1 = addr1; s_w0 = wdata0; s_w1 = wdata1;
        tick();
        if (!m_busy && e >= m_free && s_req != 2'b00) begin
          m_port  = (s_req == 2'b11) ? 1 - m_last : (s_req[1] ? 1 : 0);
          m_last  = m_port;
          m_busy  = 1'b1;
          m_rnw   = s_rnw[m_port];
          m_addr  = m_port ? s_a1 : s_a0;
          m_wd    = m_port ? s_w1 : s_w0;
          m_ack_e = e + S + H + HD;
          m_free  = e + PERIOD;
        end
        exp_ack = (m_busy && e == m_ack_e) ? (2'b01 << m_port) : 2'b00;
        if (exp_ack != 2'b00 || ack != 2'b00) check("rand_ack", {30'd0, ack}, {30'd0, exp_ack});
        if (exp_ack != 2'b00) begin
          m_busy = 1'b0;
          n_acc++;
          if (m_rnw) check("rand_rdata", {24'd0, rdata}, {24'd0, m_mem[m_addr]});
          else m_mem[m_addr] = m_wd;
        end
        for (int p = 0; p < 2; p++) begin
          if (ack[p]) begin
            pend[p] = 1'b0;
            req[p] = 1'b0;
          end else if (!pend[p] && e < 1400 && $urandom_range(0, 3) == 0) begin
            pend[p] = 1'b1;
            rnw[p] = $urandom_range(0, 1) == 1;
            if (p == 0) begin addr0 = 4'($urandom_range(0, 8)); wdata0 = 8'($urandom); end
            else begin addr1 = 4'($urandom_range(0, 8)); wdata1 = 8'($urandom); end
            req[p] = 1'b1;
          end
        end
        if (e >= 1400 && !pend[0] && !pend[1] && !m_busy) break;
      end
      check("rand_drained", {30'd0, req}, 32'd0);
      $display("txn random accesses completed=%0d", n_acc);
      tick();
      for (int i = 0; i < 9; i++)
        check("rand_final_reg", {24'd0, pk_regs[i]}, {24'd0, m_mem[i]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
